// File: rtl/ts_packet_framer_if.sv
// Upstream/downstream bus of the TS packet framer.
interface ts_packet_framer_if;
  localparam int unsigned PID_W = 13;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W = 16;

  logic              tick;
  logic              pkt_req;
  logic [PID_W-1:0]  pid;
  logic              pusi;
  logic              pkt_ack;
  logic [BYTE_W-1:0] pay_data;
  logic              pay_valid;
  logic              pay_ready;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              sop;
  logic              null_pkt;
  logic              underrun;
  logic [CNT_W-1:0]  data_cnt;
  logic [CNT_W-1:0]  null_cnt;

  modport master (
    output tick, pkt_req, pid, pusi, pay_data, pay_valid,
    input  pkt_ack, pay_ready, byte_out, byte_valid, sop, null_pkt,
           underrun, data_cnt, null_cnt
  );

  modport slave (
    input  tick, pkt_req, pid, pusi, pay_data, pay_valid,
    output pkt_ack, pay_ready, byte_out, byte_valid, sop, null_pkt,
           underrun, data_cnt, null_cnt
  );
endinterface

// File: rtl/ts_packet_framer.sv
// Emits 188-byte MPEG-TS packets, one byte per tick; null packets fill idle slots.
module ts_packet_framer (
  input  logic               clk,
  input  logic               rst,
  ts_packet_framer_if.slave  bus
);
  localparam int unsigned PKT_LEN = 188;
  localparam int unsigned HDR_LEN = 4;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned CC_W    = 4;
  localparam int unsigned CNT_W   = 16;
  localparam logic [7:0]  SYNC    = 8'h47;
  localparam logic [7:0]  STUFF   = 8'hFF;

  typedef enum logic {MODE_NULL = 1'b0, MODE_DATA = 1'b1} mode_t;

  logic [IDX_W-1:0] idx, idx_nxt;
  mode_t            mode, mode_nxt;
  logic [CC_W-1:0]  cc, cc_nxt;
  logic [12:0]      pid_q, pid_nxt;
  logic             pusi_q, pusi_nxt;

  logic             start;
  logic             in_hdr;
  logic             cur_data;
  logic             pkt_ack_c;
  logic             pay_ready_c;
  logic [7:0]       byte_nxt;
  logic             underrun_nxt;

  logic [7:0]       byte_q;
  logic             valid_q, sop_q, null_q, underrun_q;
  logic [CNT_W-1:0] dcnt_q, ncnt_q;

  assign start  = bus.tick & (idx == IDX_W'(0));
  assign in_hdr = (idx < IDX_W'(HDR_LEN));
  // Mode of the byte being built: decided live at idx 0, latched afterwards.
  assign cur_data = start ? bus.pkt_req : (mode == MODE_DATA);

  // State register: packet index, mode, continuity counter, latched header fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      mode   <= MODE_NULL;
      cc     <= '0;
      pid_q  <= '0;
      pusi_q <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      mode   <= mode_nxt;
      cc     <= cc_nxt;
      pid_q  <= pid_nxt;
      pusi_q <= pusi_nxt;
    end
  end

  // Next-state: advance idx per tick, choose packet type at idx 0, bump cc after a data header.
  always_comb begin
    idx_nxt  = idx;
    mode_nxt = mode;
    cc_nxt   = cc;
    pid_nxt  = pid_q;
    pusi_nxt = pusi_q;
    if (bus.tick) begin
      idx_nxt = (idx == IDX_W'(PKT_LEN - 1)) ? '0 : idx + IDX_W'(1);
      if (idx == IDX_W'(0)) begin
        mode_nxt = bus.pkt_req ? MODE_DATA : MODE_NULL;
        if (bus.pkt_req) begin
          pid_nxt  = bus.pid;
          pusi_nxt = bus.pusi;
        end
      end
      if ((idx == IDX_W'(HDR_LEN - 1)) && (mode == MODE_DATA)) begin
        cc_nxt = cc + CC_W'(1);
      end
    end
  end

  // Output decode: handshakes and the byte to be registered on this tick.
  always_comb begin
    pkt_ack_c    = start & bus.pkt_req;
    pay_ready_c  = bus.tick & (mode == MODE_DATA) & ~in_hdr;
    byte_nxt     = STUFF;
    underrun_nxt = 1'b0;
    case (idx)
      IDX_W'(0): byte_nxt = SYNC;
      IDX_W'(1): byte_nxt = cur_data ? {1'b0, pusi_q, 1'b0, pid_q[12:8]} : 8'h1F;
      IDX_W'(2): byte_nxt = cur_data ? pid_q[7:0] : 8'hFF;
      IDX_W'(3): byte_nxt = cur_data ? {4'b0001, cc} : 8'h10;
      default: begin
        if (cur_data && bus.pay_valid) begin
          byte_nxt = bus.pay_data;
        end
        underrun_nxt = cur_data & ~bus.pay_valid;
      end
    endcase
  end

  // Output register: one-cycle latency from tick to byte, plus packet counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      null_q     <= 1'b0;
      underrun_q <= 1'b0;
      dcnt_q     <= '0;
      ncnt_q     <= '0;
    end else if (bus.tick) begin
      byte_q     <= byte_nxt;
      valid_q    <= 1'b1;
      sop_q      <= (idx == IDX_W'(0));
      null_q     <= ~cur_data;
      underrun_q <= underrun_nxt;
      if (idx == IDX_W'(0)) begin
        if (bus.pkt_req) dcnt_q <= dcnt_q + CNT_W'(1);
        else             ncnt_q <= ncnt_q + CNT_W'(1);
      end
    end else begin
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      underrun_q <= 1'b0;
    end
  end

  assign bus.pkt_ack    = pkt_ack_c;
  assign bus.pay_ready  = pay_ready_c;
  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.sop        = sop_q;
  assign bus.null_pkt   = null_q;
  assign bus.underrun   = underrun_q;
  assign bus.data_cnt   = dcnt_q;
  assign bus.null_cnt   = ncnt_q;
endmodule
